// File: rtl/iterative_muldiv_alu.sv
// Registered execute unit: single-cycle simple ops plus iterative 1-bit-per-cycle
// unsigned multiply (shift-add) and divide (restoring), with a start/busy/done handshake.
module iterative_muldiv_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [WIDTH-1:0] SHAMT_LIMIT = WIDTH'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    // Handshake: an op is accepted on a rising edge where start=1, busy=0 and
    // abort=0; done is a one-cycle pulse marking result/result_hi/div_by_zero valid.

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_dbz;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic [WIDTH-1:0] w_simple;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign w_accept = start && (r_state == S_IDLE) && !abort;
    assign w_is_mul = (op == 4'd2) || (op == 4'd9);
    assign w_is_div = (op == 4'd10) || (op == 4'd11);

    always_comb begin
        w_simple = '0;
        case (op)
            4'd1:    w_simple = src1 - src2;
            4'd3:    w_simple = (src2 >= SHAMT_LIMIT) ? '0 : (src1 << src2);
            4'd4:    w_simple = (src2 >= SHAMT_LIMIT) ? '0 : (src1 >> src2);
            4'd5:    w_simple = src1 & src2;
            4'd6:    w_simple = src1 | src2;
            4'd7:    w_simple = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            4'd8:    w_simple = {src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: w_simple = src1 + src2;
        endcase
    end

    // Multiply: {r_hi,r_lo} starts as {0, multiplier}; add multiplicand into the
    // high half when the current low bit is set, then shift the pair right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and
    // quotient bits in.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
    assign w_div_diff  = w_div_shift - {1'b0, r_a};
    assign w_div_hi    = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};

    assign w_step_hi = (r_state == S_DIV) ? w_div_hi : w_mul_hi;
    assign w_step_lo = (r_state == S_DIV) ? w_div_lo : w_mul_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                            r_cnt   <= CNT_LOAD;
                            r_a     <= src1;
                            r_hi    <= '0;
                            r_lo    <= src2;
                        end else if (w_is_div && (src2 == '0)) begin
                            r_done      <= 1'b1;
                            r_result    <= '1;
                            r_result_hi <= src1;
                            r_dbz       <= 1'b1;
                        end else if (w_is_div) begin
                            r_state <= S_DIV;
                            r_cnt   <= CNT_LOAD;
                            r_a     <= src2;
                            r_hi    <= '0;
                            r_lo    <= src1;
                        end else begin
                            r_done      <= 1'b1;
                            r_result    <= w_simple;
                            r_result_hi <= '0;
                            r_dbz       <= 1'b0;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_hi <= w_step_hi;
                        r_lo <= w_step_lo;
                        if (r_cnt == CNT_LAST) begin
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_done      <= 1'b1;
                            r_result    <= w_step_lo;
                            r_result_hi <= w_step_hi;
                            r_dbz       <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_LAST;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_iterative_muldiv_alu.sv
// Directed bench for iterative_muldiv_alu: table of hand-computed vectors plus
// hand-written sequences for busy-time start, abort, and asynchronous reset.
module tb_iterative_muldiv_alu;

    localparam int W = 16;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         dbz;
        int           edges;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [3:0]   op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    logic [W-1:0] exp_q[$];

    iterative_muldiv_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .op(op),
        .src1(src1),
        .src2(src2),
        .busy(busy),
        .done(done),
        .result(result),
        .result_hi(result_hi),
        .div_by_zero(div_by_zero),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic [W-1:0] hi, input logic dbz,
                           input int edges);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = res; v.hi = hi; v.dbz = dbz; v.edges = edges;
        vecs.push_back(v);
    endtask

    // Drive one request; returns edges from accept to done and busy samples seen.
    task automatic apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges, output int busy_n);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        busy_n = 0;
        while (!done && edges < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        int busy_n;
        int done_n;
        logic [W-1:0] exp_v;

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; op = '0; src1 = '0; src2 = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_hi", 32'(result_hi), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add_vec(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 0);
        add_vec(4'd1,  16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 0);
        add_vec(4'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, W);
        add_vec(4'd9,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, W);
        add_vec(4'd9,  16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, W);
        add_vec(4'd2,  16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, W);
        add_vec(4'd10, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, W);
        add_vec(4'd11, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, W);
        add_vec(4'd10, 16'd3,    16'd9,    16'd0,    16'd3,    1'b0, W);
        add_vec(4'd10, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, W);
        add_vec(4'd10, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 0);
        add_vec(4'd11, 16'd7,    16'd0,    16'hFFFF, 16'd7,    1'b1, 0);
        add_vec(4'd7,  16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0, 0);
        add_vec(4'd7,  16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 0);
        add_vec(4'd3,  16'h0001, 16'd16,   16'h0000, 16'h0000, 1'b0, 0);
        add_vec(4'd3,  16'h0001, 16'd15,   16'h8000, 16'h0000, 1'b0, 0);
        add_vec(4'd3,  16'h00F0, 16'h0100, 16'h0000, 16'h0000, 1'b0, 0);
        add_vec(4'd4,  16'h8000, 16'd15,   16'h0001, 16'h0000, 1'b0, 0);
        add_vec(4'd4,  16'h8000, 16'd16,   16'h0000, 16'h0000, 1'b0, 0);
        add_vec(4'd5,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 0);
        add_vec(4'd6,  16'hF000, 16'h000F, 16'hF00F, 16'h0000, 1'b0, 0);
        add_vec(4'd8,  16'h0000, 16'h00AB, 16'hAB00, 16'h0000, 1'b0, 0);
        add_vec(4'd8,  16'h0000, 16'h12AB, 16'hAB00, 16'h0000, 1'b0, 0);
        add_vec(4'd12, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 0);
        add_vec(4'd15, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 1'b0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i].res);
            apply(vecs[i].op, vecs[i].a, vecs[i].b, edges, busy_n);
            check($sformatf("v%0d_done", i), 32'(done), 32'd1);
            exp_v = exp_q.pop_front();
            check($sformatf("v%0d_result", i), 32'(result), 32'(exp_v));
            check($sformatf("v%0d_result_hi", i), 32'(result_hi), 32'(vecs[i].hi));
            check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].edges));
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].edges));
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start pulsed while a multiply is in flight must be ignored
        @(negedge clk);
        start = 1'b1; op = 4'd9; src1 = 16'h0100; src2 = 16'h0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_mul_accept", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b1; op = 4'd0; src1 = 16'h0001; src2 = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_ignored", 32'(busy), 32'd1);
        check("no_done_start_ignored", 32'(done), 32'd0);
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("ignored_mul_latency", 32'(edges), 32'(W));
        check("ignored_mul_result", 32'(result), 32'h0000);
        check("ignored_mul_result_hi", 32'(result_hi), 32'h0001);

        // abort on cycle 5 of a multiply
        apply(4'd0, 16'd2, 16'd3, edges, busy_n);
        check("pre_abort_result", 32'(result), 32'd5);
        @(negedge clk);
        start = 1'b1; op = 4'd9; src1 = 16'h0003; src2 = 16'h0005;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        done_n = done ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        check("abort_result_kept", 32'(result), 32'd5);
        check("abort_result_hi_kept", 32'(result_hi), 32'd0);

        // abort and start together while idle: start is dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 4'd0; src1 = 16'd9; src2 = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("abort_start_done2", 32'(done), 32'd0);
        check("abort_start_result", 32'(result), 32'd5);

        // asynchronous reset in the middle of a divide
        apply(4'd10, 16'd9, 16'd0, edges, busy_n);
        check("pre_rst_dbz", 32'(div_by_zero), 32'd1);
        @(negedge clk);
        start = 1'b1; op = 4'd10; src1 = 16'd100; src2 = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_result_hi", 32'(result_hi), 32'd0);
        check("async_rst_dbz", 32'(div_by_zero), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd0, 16'd7, 16'd8, edges, busy_n);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_result", 32'(result), 32'd15);
        check("post_rst_latency", 32'(edges), 32'd0);
        check("post_rst_busy", 32'(busy_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
